// File: rtl/quad_step_decoder.sv
// ---------------------------------------------------------------------------
// quad_step_decoder
//
// Turns a 2-phase quadrature (Gray-code) input pair into step/direction
// commands for the downstream up/down counter datapath. It keeps a wrapping
// position count and raises a sticky flag on illegal phase jumps.
//
// Parameters
//   WIDTH        width of the position count
//   SYNC_STAGES  flops in each input synchronizer chain (must be >= 2)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   a_in   in   phase A, asynchronous to clk
//   b_in   in   phase B, asynchronous to clk
//   clear  in   synchronous clear of count and err
//   up     out  direction of the last valid step (1 = increment)
//   step   out  one-cycle registered pulse per valid phase transition
//   count  out  position, modulo 2^WIDTH
//   err    out  sticky illegal-transition flag
//
// There is no valid/ready handshake on this block: step is a
// fire-and-forget strobe. The consumer samples up/count on every cycle in
// which step is high; there is no back-pressure and step is never held.
//
// Phase order (AB), forward direction: 00 -> 01 -> 11 -> 10 -> 00.
// ---------------------------------------------------------------------------
module quad_step_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clear,
  output logic             up,
  output logic             step,
  output logic [WIDTH-1:0] count,
  output logic             err
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  // Start-up control. ST_FILL covers the cycles in which cur_ab still
  // carries the reset value of the synchronizers, plus the cycle in which
  // the first real sample arrives. That first sample only seeds prev_ab,
  // so inputs resting at any phase (e.g. 11) during reset never count as
  // a step or an illegal jump.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Classification of the prev_ab -> cur_ab move.
  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_FWD  = 2'd1,
    TR_REV  = 2'd2,
    TR_BAD  = 2'd3
  } trans_t;

  // Synchronizer chains; index 0 is the flop nearest the pin.
  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic [1:0]             cur_ab;
  logic [1:0]             prev_ab;

  state_t                 state;
  state_t                 state_nx;
  logic [FILL_W-1:0]      fill_cnt;
  logic [FILL_W-1:0]      fill_nx;

  trans_t                 tr;

  logic [WIDTH-1:0]       count_nx;
  logic                   up_nx;
  logic                   step_nx;
  logic                   err_nx;

  assign cur_ab = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

  // -------------------------------------------------------------------------
  // Input synchronizers and previous-phase register. prev_ab follows cur_ab
  // every cycle, whatever the control state or clear is doing, so a
  // transition is always judged against the phase seen one cycle earlier.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sync  <= '0;
      b_sync  <= '0;
      prev_ab <= 2'b00;
    end else begin
      a_sync  <= {a_sync[SYNC_STAGES-2:0], a_in};
      b_sync  <= {b_sync[SYNC_STAGES-2:0], b_in};
      prev_ab <= cur_ab;
    end
  end

  // -------------------------------------------------------------------------
  // Transition decode. Exactly one bit changing is a legal quarter-step;
  // both bits changing means a phase was missed and the direction is
  // unknowable.
  // -------------------------------------------------------------------------
  always_comb begin
    tr = TR_BAD;
    case ({prev_ab, cur_ab})
      4'b0000, 4'b0101, 4'b1111, 4'b1010: tr = TR_NONE;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: tr = TR_FWD;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: tr = TR_REV;
      default:                            tr = TR_BAD;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_FILL;
      fill_cnt <= '0;
      count    <= '0;
      up       <= 1'b0;
      step     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_nx;
      count    <= count_nx;
      up       <= up_nx;
      step     <= step_nx;
      err      <= err_nx;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    fill_nx  = fill_cnt;
    count_nx = count;
    up_nx    = up;
    step_nx  = 1'b0;
    err_nx   = err;

    case (state)
      ST_FILL: begin
        // fill_cnt reaches SYNC_STAGES on the cycle the first real sample
        // sits in cur_ab; that cycle is still suppressed.
        if (fill_cnt == FILL_W'(SYNC_STAGES)) begin
          state_nx = ST_RUN;
        end else begin
          fill_nx = fill_cnt + FILL_W'(1);
        end
      end

      ST_RUN: begin
        case (tr)
          TR_FWD: begin
            step_nx  = 1'b1;
            up_nx    = 1'b1;
            count_nx = count + WIDTH'(1);
          end
          TR_REV: begin
            step_nx  = 1'b1;
            up_nx    = 1'b0;
            count_nx = count - WIDTH'(1);
          end
          TR_BAD: begin
            err_nx = 1'b1;
          end
          default: begin
            // no movement: everything holds
          end
        endcase
      end

      default: begin
        state_nx = ST_FILL;
        fill_nx  = '0;
      end
    endcase

    // clear swallows whatever transition coincides with it: the move is
    // neither counted nor flagged, and the direction keeps its old value.
    if (clear) begin
      count_nx = '0;
      err_nx   = 1'b0;
      step_nx  = 1'b0;
      up_nx    = up;
    end
  end

endmodule
